// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ctrl_pkg
// Purpose  : Command mode encodings and sequencer state type for pwm_fade_ctrl.
// Revision : 1.0
// ============================================================================
package pwm_ctrl_pkg;

   localparam logic [1:0] MODE_SET     = 2'b00;
   localparam logic [1:0] MODE_RAMP    = 2'b01;
   localparam logic [1:0] MODE_BREATHE = 2'b10;
   localparam logic [1:0] MODE_OFF     = 2'b11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_BND = 3'd1,
      RAMP     = 3'd2,
      BR_UP    = 3'd3,
      BR_DN    = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_core.sv
`default_nettype none
// ============================================================================
// Module   : pwm_core
// Purpose  : Free-running R-bit PWM counter, period boundary tick and registered
//            compare output. PWM_INVERT_EN inverts the output after the register.
// Revision : 1.0
// ============================================================================
module pwm_core #(
   parameter int R = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [R-1:0] duty,
   output logic         bnd,
   output logic         pwm_out
);

   logic [R-1:0] r_cnt;
   logic         r_pwm;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_pwm <= 1'b0;
      end else begin
         r_cnt <= r_cnt + R'(1);
         r_pwm <= (r_cnt < duty);
      end
   end

   assign bnd = (r_cnt == {R{1'b1}});

`ifdef PWM_INVERT_EN
   assign pwm_out = ~r_pwm;
`else
   assign pwm_out = r_pwm;
`endif

endmodule
`default_nettype wire

// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_ctrl
// Purpose  : Duty sequencer (set / ramp / breathe / off) driving pwm_core;
//            duty only changes on PWM period boundaries. Honors PWM_INVERT_EN.
// Revision : 1.0
// ============================================================================
module pwm_fade_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int R = 6,
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_mode,
   input  logic [R-1:0] cmd_target,
   output logic         busy,
   output logic         done,
   output logic [R-1:0] duty,
   output logic         pwm_out
);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [1:0]   r_mode;
   logic [R-1:0] r_target;
   logic [R-1:0] r_duty;
   logic [R-1:0] w_duty_nxt;
   logic         r_done;
   logic         w_done_nxt;
   logic [N-1:0] r_step;
   logic         w_bnd;
   logic         w_stp;
   logic         w_accept;

   pwm_core #(.R(R)) u_core (
      .clk     (clk),
      .reset   (reset),
      .duty    (r_duty),
      .bnd     (w_bnd),
      .pwm_out (pwm_out)
   );

   assign cmd_ready = (r_state == IDLE) || (r_state == BR_UP) || (r_state == BR_DN);
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_stp     = w_bnd && (r_step == {N{1'b1}});
   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign duty      = r_duty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // An accepted command takes priority over any boundary/step in the same clock.
   always_comb begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      w_done_nxt  = 1'b0;
      if (w_accept) begin
         case (cmd_mode)
            MODE_SET, MODE_OFF: w_state_nxt = WAIT_BND;
            MODE_RAMP:          w_state_nxt = RAMP;
            MODE_BREATHE:       w_state_nxt = BR_UP;
            default:            w_state_nxt = WAIT_BND;
         endcase
      end else begin
         case (r_state)
            WAIT_BND: begin
               if (w_bnd) begin
                  w_duty_nxt  = (r_mode == MODE_OFF) ? '0 : r_target;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            RAMP: begin
               if (r_duty == r_target) begin
                  if (w_bnd) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end else if (w_stp) begin
                  w_duty_nxt = (r_duty < r_target) ? r_duty + R'(1) : r_duty - R'(1);
               end
            end
            BR_UP: begin
               if (r_duty > r_target) begin
                  if (w_bnd) w_duty_nxt = r_target;
               end else if (r_duty == r_target) begin
                  if (r_target != '0) w_state_nxt = BR_DN;
               end else if (w_stp) begin
                  w_duty_nxt = r_duty + R'(1);
               end
            end
            BR_DN: begin
               if (r_duty == '0) begin
                  w_state_nxt = BR_UP;
               end else if (w_stp) begin
                  w_duty_nxt = r_duty - R'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_duty   <= '0;
         r_done   <= 1'b0;
         r_mode   <= MODE_SET;
         r_target <= '0;
         r_step   <= '0;
      end else begin
         r_duty <= w_duty_nxt;
         r_done <= w_done_nxt;
         if (w_accept) begin
            r_mode   <= cmd_mode;
            r_target <= cmd_target;
            r_step   <= '0;
         end else if (w_bnd) begin
            r_step <= r_step + N'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_fade_ctrl
// Purpose  : Scoreboard bench for pwm_fade_ctrl against an event-time model.
// Revision : 1.0
// ============================================================================
module tb_pwm_fade_ctrl;
   import pwm_ctrl_pkg::*;

   localparam int R   = 6;
   localparam int N   = 3;
   localparam int PER = 1 << R;
   localparam int SPB = 1 << N;
`ifdef PWM_INVERT_EN
   localparam int PWM_IDLE = 1;
`else
   localparam int PWM_IDLE = 0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         cmd_valid = 1'b0;
   logic [1:0]   cmd_mode = 2'b00;
   logic [R-1:0] cmd_target = '0;
   logic         cmd_ready, busy, done, pwm_out;
   logic [R-1:0] duty;

   pwm_fade_ctrl #(.R(R), .N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_target (cmd_target),
      .busy       (busy),
      .done       (done),
      .duty       (duty),
      .pwm_out    (pwm_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int edge_n;
      bit is_done;
      int val;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_ev;
   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   bit  mon_en = 1'b0;
   int  m_duty = 0;
   int  free_edge = 0;
   bit  m_breathe = 1'b0;
   int  last_b0 = 0;
   int  hi_cnt = 0, per_duty = 0, ref_duty = 0, prev_duty = 0;

   // Edge number: 1 on the first rising edge after reset release.
   always @(posedge clk) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input int act, input int want);
      n_checks++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, want, cyc);
      end
   endtask

   function automatic void push(input int e, input bit dn, input int v);
      ev_t ev;
      ev.edge_n  = e;
      ev.is_done = dn;
      ev.val     = v;
      exp_q.push_back(ev);
   endfunction

   // Monitor: pops the expected event whenever duty changes or done pulses,
   // and checks the high time of each finished PWM period.
   always @(negedge clk) begin
      if (mon_en && cyc > 0) begin
         if (int'(pwm_out) != PWM_IDLE) hi_cnt++;
         if (cyc % PER == 0) begin
            check("pwm_high_count", hi_cnt, per_duty);
            hi_cnt = 0;
         end
         if (int'(duty) != prev_duty) begin
            if (exp_q.size() == 0 || exp_q[0].is_done) begin
               check("unexpected_duty_change", int'(duty), prev_duty);
            end else begin
               mon_ev = exp_q.pop_front();
               check("duty_edge", cyc, mon_ev.edge_n);
               check("duty_value", int'(duty), mon_ev.val);
               ref_duty = mon_ev.val;
            end
            prev_duty = int'(duty);
         end
         if (done) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
               check("unexpected_done", int'(done), 0);
            end else begin
               mon_ev = exp_q.pop_front();
               check("done_edge", cyc, mon_ev.edge_n);
            end
         end
         if (cyc % PER == 0) per_duty = ref_duty;
      end
   end

   // Issues one command at the earliest model-predicted ready point and pushes
   // the predicted duty/done events. Called and returns on a falling edge.
   task automatic issue(input logic [1:0] mode, input int tgt, input int nsteps);
      int a, b0, d, n, v;
      bit up;
      while (cyc + 1 < free_edge) @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("cmd_ready_before", int'(cmd_ready), 1);
      check("busy_before", int'(busy), int'(m_breathe));
      cmd_valid  = 1'b1;
      cmd_mode   = mode;
      cmd_target = R'(tgt);
      @(negedge clk);
      cmd_valid = 1'b0;
      a  = cyc;
      b0 = (a / PER) * PER;
      last_b0 = b0;
      check("busy_after_accept", int'(busy), 1);
      check("cmd_ready_after_accept", int'(cmd_ready), int'(mode == MODE_BREATHE));
      d = m_duty;
      m_breathe = 1'b0;
      case (mode)
         MODE_RAMP: begin
            n = (tgt > d) ? tgt - d : d - tgt;
            for (int k = 1; k <= n; k++) begin
               d = (tgt > d) ? d + 1 : d - 1;
               push(b0 + k * SPB * PER, 1'b0, d);
            end
            push(b0 + (n * SPB + 1) * PER, 1'b1, 0);
            m_duty    = tgt;
            free_edge = b0 + (n * SPB + 1) * PER + 1;
         end
         MODE_BREATHE: begin
            if (d > tgt) begin
               d = tgt;
               push(b0 + PER, 1'b0, d);
            end
            up = (d < tgt);
            for (int k = 1; k <= nsteps; k++) begin
               if (tgt != 0) begin
                  d = up ? d + 1 : d - 1;
                  push(b0 + k * SPB * PER, 1'b0, d);
                  if (d == tgt) up = 1'b0;
                  else if (d == 0) up = 1'b1;
               end
            end
            m_duty    = d;
            m_breathe = 1'b1;
            free_edge = b0 + nsteps * SPB * PER + int'($urandom_range(1, 400));
         end
         default: begin
            v = (mode == MODE_SET) ? tgt : 0;
            if (v != d) push(b0 + PER, 1'b0, v);
            push(b0 + PER, 1'b1, 0);
            m_duty    = v;
            free_edge = b0 + PER + 1;
         end
      endcase
   endtask

   task automatic restart_model();
      exp_q.delete();
      m_duty = 0; free_edge = 0; m_breathe = 1'b0;
      hi_cnt = 0; per_duty = 0; ref_duty = 0; prev_duty = 0;
   endtask

   initial begin
      logic [1:0] mode;
      int tgt, ns;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_duty", int'(duty), 0);
      check("reset_pwm_out", int'(pwm_out), PWM_IDLE);
      check("reset_cmd_ready", int'(cmd_ready), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      reset  = 1'b1;
      mon_en = 1'b1;

      issue(MODE_SET, 16, 0);
      issue(MODE_RAMP, 20, 0);
      issue(MODE_RAMP, 20, 0);
      issue(MODE_OFF, 0, 0);
      issue(MODE_BREATHE, 3, 7);
      issue(MODE_SET, 10, 0);

      for (int i = 0; i < 10; i++) begin
         mode = 2'($urandom_range(0, 3));
         ns   = 0;
         case (mode)
            MODE_RAMP: begin
               tgt = m_duty + int'($urandom_range(0, 8)) - 4;
               if (tgt < 0) tgt = 0;
               if (tgt > PER - 1) tgt = PER - 1;
            end
            MODE_BREATHE: begin
               tgt = int'($urandom_range(0, 6));
               ns  = int'($urandom_range(1, 6));
            end
            default: tgt = int'($urandom_range(0, PER - 1));
         endcase
         issue(mode, tgt, ns);
      end

      // Asynchronous reset in the middle of a ramp, while duty is 18.
      issue(MODE_SET, 16, 0);
      issue(MODE_RAMP, 20, 0);
      while (cyc < last_b0 + 2 * SPB * PER + 100) @(negedge clk);
      check("midramp_duty", int'(duty), 18);
      check("midramp_cmd_ready", int'(cmd_ready), 0);
      mon_en = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("async_rst_duty", int'(duty), 0);
      check("async_rst_pwm_out", int'(pwm_out), PWM_IDLE);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_cmd_ready", int'(cmd_ready), 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_held_done", int'(done), 0);
      end
      restart_model();
      reset  = 1'b1;
      mon_en = 1'b1;

      issue(MODE_SET, 5, 0);
      while (cyc < free_edge + PER) @(negedge clk);
      check("pending_events", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
